// File: rtl/obi_burst_writer.sv
// obi_burst_writer: OBI write-DMA with config subordinate, pattern writer and popcount; optional irq_o via OBI_BURST_WRITER_IRQ_EN
package obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;
    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;
    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module obi_burst_writer #(
    parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
    parameter type obi_req_t = obi_pkg::obi_req_t,
    parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned LenWidth = 16,
    parameter int unsigned PopWidth = 16
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_req_i,
    output obi_rsp_t sbr_rsp_o,
    output obi_req_t mgr_req_o,
    input  obi_rsp_t mgr_rsp_i
`ifdef OBI_BURST_WRITER_IRQ_EN
    ,
    output logic     irq_o
`endif
);
    localparam int unsigned AW = ObiCfg.AddrWidth;
    localparam int unsigned OW = $clog2(MaxOutstanding + 1);
    localparam logic [OW-1:0] MaxO = OW'(MaxOutstanding);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_d;

    logic [AW-1:0]       dst, cur_addr;
    logic [LenWidth-1:0] len, cnt;
    logic [31:0]         seed, cur_data, rd_mux, rdata_q;
    logic [PopWidth-1:0] popcnt;
    logic [OW-1:0]       outst;
    logic                inc, done, sts_err, rvalid_q, err_q, irq_mask;
    logic [0:0]          rid_q;
    logic [2:0]          off;
    logic                busy, bad, wr_ok, start, stat_rd, gnt_fire, rsp_fire;
    logic                unused;

    assign off     = sbr_req_i.a.addr[4:2];
    assign busy    = state != IDLE;
    assign bad     = (off > 3'd5) || (sbr_req_i.a.we && (off >= 3'd4 || busy));
    assign wr_ok   = sbr_req_i.req && sbr_req_i.a.we && !bad;
    assign start   = wr_ok && off == 3'd3 && sbr_req_i.a.wdata[0];
    assign stat_rd = sbr_req_i.req && !sbr_req_i.a.we && off == 3'd4;
    assign unused  = ^{sbr_req_i.a.addr[31:5], sbr_req_i.a.addr[1:0], sbr_req_i.a.be,
                       mgr_rsp_i.r.rdata, mgr_rsp_i.r.rid};

`ifdef OBI_BURST_WRITER_IRQ_EN
    // irq mask bit lives in CTRL and only exists in the irq build
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_mask <= 1'b0;
        else if (wr_ok && off == 3'd3) irq_mask <= sbr_req_i.a.wdata[2];
    end
    assign irq_o = done & irq_mask;
`else
    assign irq_mask = 1'b0;
`endif

    // register read mux; START always reads back as 0
    always_comb begin
        rd_mux = off == 3'd0 ? 32'(dst) :
                 off == 3'd1 ? 32'(len) :
                 off == 3'd2 ? seed :
                 off == 3'd3 ? {29'd0, irq_mask, inc, 1'b0} :
                 off == 3'd4 ? {29'd0, sts_err, done, busy} :
                 off == 3'd5 ? 32'(popcnt) : 32'd0;
    end

    // subordinate response is the registered result of the granted request
    always_comb begin
        sbr_rsp_o          = '0;
        sbr_rsp_o.gnt      = sbr_req_i.req;
        sbr_rsp_o.rvalid   = rvalid_q;
        sbr_rsp_o.r.rdata  = rdata_q;
        sbr_rsp_o.r.rid    = rid_q;
        sbr_rsp_o.r.err    = err_q;
    end

    // manager request generation and next-state logic
    always_comb begin
        state_d           = state;
        mgr_req_o         = '0;
        mgr_req_o.req     = (state == ISSUE) && (outst != MaxO);
        mgr_req_o.a.we    = 1'b1;
        mgr_req_o.a.be    = '1;
        mgr_req_o.a.addr  = cur_addr;
        mgr_req_o.a.wdata = cur_data;
        gnt_fire          = mgr_req_o.req && mgr_rsp_i.gnt;
        rsp_fire          = mgr_rsp_i.rvalid && (outst != '0);
        if (state == IDLE && start && len != '0) state_d = ISSUE;
        if (state == ISSUE && gnt_fire && cnt == len - LenWidth'(1)) state_d = DRAIN;
        if (state == DRAIN && rsp_fire && outst == OW'(1)) state_d = IDLE;
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_d;
    end

    // config registers, status flags, burst counters and popcount
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dst      <= '0;
            len      <= '0;
            seed     <= '0;
            inc      <= 1'b0;
            done     <= 1'b0;
            sts_err  <= 1'b0;
            popcnt   <= '0;
            outst    <= '0;
            cnt      <= '0;
            cur_addr <= '0;
            cur_data <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= sbr_req_i.req;
            rid_q    <= sbr_req_i.a.aid;
            err_q    <= sbr_req_i.req && bad;
            rdata_q  <= (sbr_req_i.req && !sbr_req_i.a.we && !bad) ? rd_mux : 32'd0;
            if (wr_ok && off == 3'd0) dst <= sbr_req_i.a.wdata[AW-1:0];
            if (wr_ok && off == 3'd1) len <= sbr_req_i.a.wdata[LenWidth-1:0];
            if (wr_ok && off == 3'd2) seed <= sbr_req_i.a.wdata;
            if (wr_ok && off == 3'd3) inc <= sbr_req_i.a.wdata[1];
            outst <= outst + OW'(gnt_fire) - OW'(rsp_fire);
            if (stat_rd) begin
                done    <= 1'b0;
                sts_err <= 1'b0;
            end
            if (rsp_fire && mgr_rsp_i.r.err) sts_err <= 1'b1;
            if (state == DRAIN && state_d == IDLE) done <= 1'b1;
            if (gnt_fire) begin
                cur_addr <= cur_addr + AW'(4);
                cur_data <= inc ? cur_data + 32'd1 : cur_data;
                cnt      <= cnt + LenWidth'(1);
                popcnt   <= popcnt + PopWidth'($countones(cur_data));
            end
            if (start) begin
                cur_addr <= dst;
                cur_data <= seed;
                cnt      <= '0;
                popcnt   <= '0;
                sts_err  <= 1'b0;
                done     <= len == '0;
            end
        end
    end
endmodule

// File: tb/tb_obi_burst_writer.sv
// tb_obi_burst_writer: randomized bursts against an SRAM model and a word-list reference
module tb_obi_burst_writer;
    import obi_pkg::*;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    obi_req_t sbr_req, mgr_req;
    obi_rsp_t sbr_rsp, mgr_rsp;
`ifdef OBI_BURST_WRITER_IRQ_EN
    logic irq;
`endif

    int tests = 0, fails = 0, cyc = 0;
    int lat_lo = 1, lat_hi = 1, gnt_max = 1 << 30, err_beat = -1, beat = 0, mout = 0;
    bit gnt_rand = 1'b0;
    typedef struct {int due; bit err;} pend_t;
    pend_t pend[$];
    logic [31:0] got_addr[$], got_data[$];
    logic [3:0]  got_be[$];
    logic        got_we[$];
    bit          pw = 1'b0;
    logic [31:0] pa, pd;

    always #5 clk = ~clk;

    obi_burst_writer #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .sbr_req_i(sbr_req),
        .sbr_rsp_o(sbr_rsp),
        .mgr_req_o(mgr_req),
        .mgr_rsp_i(mgr_rsp)
`ifdef OBI_BURST_WRITER_IRQ_EN
        ,
        .irq_o(irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM: grants per policy, answers in order after a random latency
    initial begin
        mgr_rsp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mout = 0;
                pw = 1'b0;
            end else begin
                if (mout == MAXO) chk("req_low_when_full", 32'(mgr_req.req), 0);
                if (pw) begin
                    chk("hold_req", 32'(mgr_req.req), 1);
                    chk("hold_addr", mgr_req.a.addr, pa);
                    chk("hold_wdata", mgr_req.a.wdata, pd);
                end
            end
            mgr_rsp.rvalid = 1'b0;
            mgr_rsp.r = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mgr_rsp.rvalid = 1'b1;
                mgr_rsp.r.err = pend[0].err;
                mgr_rsp.r.rdata = $urandom;
                void'(pend.pop_front());
                if (rst_n && mout > 0) mout--;
            end
            mgr_rsp.gnt = rst_n && beat < gnt_max && (!gnt_rand || $urandom_range(0, 1) == 1);
            if (rst_n) begin
                pw = mgr_req.req && !mgr_rsp.gnt;
                pa = mgr_req.a.addr;
                pd = mgr_req.a.wdata;
                if (mgr_req.req && mgr_rsp.gnt) begin
                    got_addr.push_back(mgr_req.a.addr);
                    got_data.push_back(mgr_req.a.wdata);
                    got_be.push_back(mgr_req.a.be);
                    got_we.push_back(mgr_req.a.we);
                    pend.push_back('{cyc + $urandom_range(lat_lo, lat_hi), beat == err_beat});
                    beat++;
                    mout++;
                end
            end
            cyc++;
        end
    end

    task automatic sbr(input bit we, input logic [7:0] off, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        logic id;
        id = 1'($urandom);
        @(negedge clk);
        sbr_req.req = 1'b1;
        sbr_req.a.we = we;
        sbr_req.a.addr = {24'h0, off};
        sbr_req.a.wdata = wd;
        sbr_req.a.be = '1;
        sbr_req.a.aid = id;
        #1 chk("sbr_gnt", 32'(sbr_rsp.gnt), 1);
        @(negedge clk);
        sbr_req = '0;
        chk("sbr_rvalid", 32'(sbr_rsp.rvalid), 1);
        chk("sbr_rid", 32'(sbr_rsp.r.rid), 32'(id));
        rd = sbr_rsp.r.rdata;
        er = sbr_rsp.r.err;
    endtask

    task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] wd, input bit exp_err);
        logic [31:0] rd;
        logic er;
        sbr(1'b1, off, wd, rd, er);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_wr_rdata"}, rd, 0);
    endtask

    task automatic rdc(input string tag, input logic [7:0] off, input logic [31:0] exp, input bit exp_err);
        logic [31:0] rd;
        logic er;
        sbr(1'b0, off, 32'h0, rd, er);
        chk(tag, rd, exp);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    task automatic cfg_start(input logic [31:0] dst, input int len, input logic [31:0] seed, input bit inc);
        beat = 0;
        got_addr.delete();
        got_data.delete();
        got_be.delete();
        got_we.delete();
        wr("wr_dst", 8'h00, dst, 1'b0);
        wr("wr_len", 8'h04, 32'(len), 1'b0);
        wr("wr_seed", 8'h08, seed, 1'b0);
        wr("wr_start", 8'h0C, {30'd0, inc, 1'b1}, 1'b0);
    endtask

    task automatic finish_check(input logic [31:0] dst, input int len, input logic [31:0] seed,
                                input bit inc, input bit err_exp);
        logic [15:0] ps;
        logic [31:0] ea, ed;
        ps = '0;
        for (int k = 0; k < 3000 && !(beat >= len && mout == 0); k++) @(negedge clk);
        chk("burst_complete", 32'(beat >= len && mout == 0), 1);
        repeat (2) @(negedge clk);
        chk("beat_count", 32'(got_addr.size()), 32'(len));
        for (int k = 0; k < len && k < got_addr.size(); k++) begin
            ea = dst + 32'(4 * k);
            ed = seed + (inc ? 32'(k) : 32'd0);
            ps += 16'($countones(ed));
            chk("beat_addr", got_addr[k], ea);
            chk("beat_wdata", got_data[k], ed);
            chk("beat_be", 32'(got_be[k]), 32'hF);
            chk("beat_we", 32'(got_we[k]), 1);
        end
        rdc("status_done", 8'h10, {29'd0, err_exp, 2'b10}, 1'b0);
        rdc("popcnt", 8'h14, 32'(ps), 1'b0);
        rdc("status_cleared", 8'h10, 32'h0, 1'b0);
    endtask

    task automatic run(input logic [31:0] dst, input int len, input logic [31:0] seed, input bit inc);
        cfg_start(dst, len, seed, inc);
        finish_check(dst, len, seed, inc, err_beat >= 0 && err_beat < len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        sbr_req = '0;
        repeat (3) @(negedge clk);
        chk("rst_mgr_req", 32'(mgr_req.req), 0);
        chk("rst_sbr_rvalid", 32'(sbr_rsp.rvalid), 0);
        #2 rst_n = 1'b1;
        rdc("rst_dst", 8'h00, 0, 1'b0);
        rdc("rst_len", 8'h04, 0, 1'b0);
        rdc("rst_seed", 8'h08, 0, 1'b0);
        rdc("rst_ctrl", 8'h0C, 0, 1'b0);
        rdc("rst_status", 8'h10, 0, 1'b0);
        rdc("rst_popcnt", 8'h14, 0, 1'b0);

        run(32'h1000_0000, 4, 32'hF, 1'b1);
        rdc("ctrl_inc_readback", 8'h0C, 32'h2, 1'b0);

        lat_lo = 5;
        lat_hi = 5;
        s = $urandom;
        cfg_start(32'h2000_0000, 4, s, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("two_outstanding_only", 32'(beat), 2);
        finish_check(32'h2000_0000, 4, s, 1'b0, 1'b0);

        cfg_start(32'h3000_0000, 0, 32'h5, 1'b1);
        repeat (5) @(negedge clk);
        chk("len0_no_beats", 32'(beat), 0);
        rdc("len0_status", 8'h10, 32'h2, 1'b0);

        lat_lo = 6;
        lat_hi = 6;
        s = $urandom;
        cfg_start(32'h4000_0100, 10, s, 1'b1);
        wr("busy_wr_len", 8'h04, 32'h3, 1'b1);
        wr("busy_wr_dst", 8'h00, 32'h1234, 1'b1);
        rdc("busy_len_kept", 8'h04, 32'd10, 1'b0);
        rdc("busy_status", 8'h10, 32'h1, 1'b0);
        finish_check(32'h4000_0100, 10, s, 1'b1, 1'b0);
        rdc("bad_offset", 8'h18, 0, 1'b1);
        wr("wr_status_ro", 8'h10, 32'h7, 1'b1);
        wr("wr_popcnt_ro", 8'h14, 32'h7, 1'b1);

        lat_lo = 1;
        lat_hi = 2;
        err_beat = 1;
        run(32'h5000_0000, 3, $urandom, 1'b1);
        err_beat = -1;

        wr("wr_ctrl_mask", 8'h0C, 32'h4, 1'b0);
`ifdef OBI_BURST_WRITER_IRQ_EN
        rdc("ctrl_mask_bit", 8'h0C, 32'h4, 1'b0);
`else
        rdc("ctrl_mask_bit", 8'h0C, 32'h0, 1'b0);
`endif

        for (int t = 0; t < 6; t++) begin
            gnt_rand = 1'($urandom_range(0, 1));
            lat_lo = 1;
            lat_hi = $urandom_range(1, 4);
            err_beat = (t == 2) ? 0 : -1;
            run(t == 0 ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC), $urandom_range(1, 10),
                $urandom, 1'($urandom_range(0, 1)));
        end
        err_beat = -1;
        gnt_rand = 1'b0;

        lat_lo = 6;
        lat_hi = 6;
        err_beat = 0;
        gnt_max = 1;
        cfg_start(32'h6000_0000, 5, $urandom, 1'b1);
        for (int k = 0; k < 100 && beat < 1; k++) @(negedge clk);
        chk("one_outstanding", 32'(beat), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst_mgr_req", 32'(mgr_req.req), 0);
        chk("midrst_sbr_rvalid", 32'(sbr_rsp.rvalid), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        err_beat = -1;
        gnt_max = 1 << 30;
        for (int k = 0; k < 100 && pend.size() > 0; k++) @(negedge clk);
        chk("late_rsp_delivered", 32'(pend.size()), 0);
        rdc("post_rst_status", 8'h10, 0, 1'b0);
        rdc("post_rst_popcnt", 8'h14, 0, 1'b0);
        rdc("post_rst_dst", 8'h00, 0, 1'b0);
        lat_lo = 1;
        lat_hi = 3;
        run(32'h7000_0040, 7, $urandom, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
